// File: rtl/lse_add_pipe_if.sv
// Operand/result handshake bundle for lse_add_pipe.
// master = producer/consumer side, slave = the adder pipeline.
interface lse_add_pipe_if #(
   parameter int WIDTH = 24
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] in_a;
   logic signed [WIDTH-1:0] in_b;
   logic [1:0]              in_mode;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_result;

   modport master (
      output in_valid, in_a, in_b, in_mode, out_ready,
      input  in_ready, out_valid, out_result
   );

   modport slave (
      input  in_valid, in_a, in_b, in_mode, out_ready,
      output in_ready, out_valid, out_result
   );
endinterface

// File: rtl/lse_add_pipe.sv
// Three-stage log-sum-exp adder: max(a,b) + lut[|a-b|] in full width, per-lane max in packed modes.
// Optional statistics counters are enabled by defining LSE_ADD_PIPE_STATS_EN.
module lse_add_pipe #(
   parameter  int WIDTH         = 24,
   parameter  int LUT_SIZE      = 1024,
   parameter  int LUT_PRECISION = 10,
   parameter  int DIFF_SHIFT    = 0,
   parameter  int STAT_WIDTH    = 32,
   localparam int AW            = $clog2(LUT_SIZE)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   lse_add_pipe_if.slave            bus,
   input  logic                     lut_we,
   input  logic [AW-1:0]            lut_addr,
   input  logic [LUT_PRECISION-1:0] lut_wdata,
   output logic [STAT_WIDTH-1:0]    stat_ops,
   output logic [STAT_WIDTH-1:0]    stat_sat
);

   localparam logic [WIDTH-1:0] NEG_INF  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH:0]   LUT_LIM  = (WIDTH+1)'(LUT_SIZE);
   localparam logic [AW:0]      ADDR_LIM = (AW+1)'(LUT_SIZE);

   function automatic logic [5:0] fld6_max(input logic [5:0] a, input logic [5:0] b);
      if (a == 6'h20) return b;
      if (b == 6'h20) return a;
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   function automatic logic [11:0] fld12_max(input logic [11:0] a, input logic [11:0] b);
      if (a == 12'h800) return b;
      if (b == 12'h800) return a;
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   function automatic logic [WIDTH-1:0] lane6_max(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int l = 0; l < WIDTH/6; l++) r[l*6 +: 6] = fld6_max(a[l*6 +: 6], b[l*6 +: 6]);
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] lane12_max(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int l = 0; l < WIDTH/12; l++) r[l*12 +: 12] = fld12_max(a[l*12 +: 12], b[l*12 +: 12]);
      return r;
   endfunction

   // corr is never negative, so only positive overflow can occur
   function automatic logic sat_ovf(input logic signed [WIDTH:0] s);
      return !s[WIDTH] && s[WIDTH-1];
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_pos(input logic signed [WIDTH:0] s);
      if (sat_ovf(s)) return {1'b0, {(WIDTH-1){1'b1}}};
      return s[WIDTH-1:0];
   endfunction

   logic                     r_vld_p1, r_vld_p2, r_vld_p3;
   logic signed [WIDTH-1:0]  r_mx_p1, r_mx_p2, r_res_p3;
   logic [AW-1:0]            r_idx_p1;
   logic                     r_cor_en_p1;
   logic [LUT_PRECISION-1:0] r_corr_p2;
   logic [LUT_PRECISION-1:0] r_lut [LUT_SIZE];

   logic w_s1_load, w_s1_adv, w_s2_load, w_s2_adv, w_s3_load;

   assign w_s3_load = !r_vld_p3 || bus.out_ready;
   assign w_s2_adv  = r_vld_p2 && w_s3_load;
   assign w_s2_load = !r_vld_p2 || w_s2_adv;
   assign w_s1_adv  = r_vld_p1 && w_s2_load;
   assign w_s1_load = !r_vld_p1 || w_s1_adv;

   assign bus.in_ready   = w_s1_load;
   assign bus.out_valid  = r_vld_p3;
   assign bus.out_result = r_res_p3;

   logic signed [WIDTH-1:0] w_a, w_b, w_mx, w_mn, w_sel;
   logic [WIDTH-1:0]        w_d, w_idx_full, w_pk;
   logic                    w_a_ninf, w_b_ninf, w_packed, w_cor_en;

   assign w_a        = bus.in_a;
   assign w_b        = bus.in_b;
   assign w_a_ninf   = (w_a == NEG_INF);
   assign w_b_ninf   = (w_b == NEG_INF);
   assign w_packed   = (bus.in_mode == 2'b01) || (bus.in_mode == 2'b10);
   assign w_mx       = (w_a >= w_b) ? w_a : w_b;
   assign w_mn       = (w_a >= w_b) ? w_b : w_a;
   assign w_d        = w_mx - w_mn;
   assign w_idx_full = w_d >> DIFF_SHIFT;
   assign w_pk       = (bus.in_mode == 2'b01) ? lane6_max(w_a, w_b) : lane12_max(w_a, w_b);
   assign w_cor_en   = !w_packed && !w_a_ninf && !w_b_ninf && ({1'b0, w_idx_full} < LUT_LIM);

   always_comb begin
      w_sel = w_mx;
      if (w_packed)      w_sel = w_pk;
      else if (w_a_ninf) w_sel = w_b;
      else if (w_b_ninf) w_sel = w_a;
   end

   logic signed [WIDTH:0] w_sum;
   assign w_sum = {r_mx_p2[WIDTH-1], r_mx_p2} + {{(WIDTH+1-LUT_PRECISION){1'b0}}, r_corr_p2};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
         r_vld_p3 <= 1'b0;
         r_res_p3 <= '0;
      end else begin
         if (w_s1_load) r_vld_p1 <= bus.in_valid;
         if (w_s2_load) r_vld_p2 <= r_vld_p1;
         if (w_s3_load) r_vld_p3 <= r_vld_p2;
         // S3: add correction and clamp
         if (w_s3_load && r_vld_p2) r_res_p3 <= sat_pos(w_sum);
      end
   end

   always_ff @(posedge clk) begin
      // S1: select max / special case, form LUT index
      if (w_s1_load && bus.in_valid) begin
         r_mx_p1     <= w_sel;
         r_idx_p1    <= w_idx_full[AW-1:0];
         r_cor_en_p1 <= w_cor_en;
      end
      // S2: LUT read; a same-edge write is not yet visible here
      if (w_s2_load && r_vld_p1) begin
         r_mx_p2   <= r_mx_p1;
         r_corr_p2 <= r_cor_en_p1 ? r_lut[r_idx_p1] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LUT_SIZE; i++) r_lut[i] <= '0;
      end else if (lut_we && ({1'b0, lut_addr} < ADDR_LIM)) begin
         r_lut[lut_addr] <= lut_wdata;
      end
   end

`ifdef LSE_ADD_PIPE_STATS_EN
   logic                  r_sat_p3;
   logic [STAT_WIDTH-1:0] r_stat_ops, r_stat_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_p3   <= 1'b0;
         r_stat_ops <= '0;
         r_stat_sat <= '0;
      end else begin
         if (w_s3_load && r_vld_p2) r_sat_p3 <= sat_ovf(w_sum);
         if (r_vld_p3 && bus.out_ready) begin
            r_stat_ops <= r_stat_ops + 1'b1;
            if (r_sat_p3) r_stat_sat <= r_stat_sat + 1'b1;
         end
      end
   end

   assign stat_ops = r_stat_ops;
   assign stat_sat = r_stat_sat;
`else
   assign stat_ops = '0;
   assign stat_sat = '0;
`endif

endmodule

// File: tb/tb_lse_add_pipe.sv
// Directed bench for lse_add_pipe: special cases, packed lanes, saturation,
// backpressure, LUT write/read ordering and asynchronous reset.
module tb_lse_add_pipe;
   localparam int W = 24;
`ifdef LSE_ADD_PIPE_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lut_we;
   logic [9:0]  lut_addr;
   logic [9:0]  lut_wdata;
   logic [31:0] stat_ops, stat_sat;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   lse_add_pipe_if #(.WIDTH(W)) bus ();

   lse_add_pipe #(
      .WIDTH(W), .LUT_SIZE(1024), .LUT_PRECISION(10), .DIFF_SHIFT(0), .STAT_WIDTH(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
      .stat_ops(stat_ops), .stat_sat(stat_sat)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic write_lut(input int addr, input int data);
      lut_addr  = 10'(addr);
      lut_wdata = 10'(data);
      lut_we    = 1'b1;
      @(posedge clk); #1;
      lut_we    = 1'b0;
   endtask

   task automatic load_lut_identity();
      lut_we = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         lut_addr  = 10'(i);
         lut_wdata = 10'(i);
         @(posedge clk); #1;
      end
      lut_we = 1'b0;
   endtask

   // Issues one op into an empty pipeline; lat counts edges including the accepting one.
   task automatic issue_and_collect(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] m, output logic [W-1:0] got,
                                    output int lat);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_mode  = m;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      got = bus.out_result;
      if (!bus.out_valid) lat = -1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = 2'b00;
      bus.out_ready = 1'b1;
      #3;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.out_result !== 24'h0) begin bad++; $display("FAIL reset_out_result got=%h want=000000", bus.out_result); end
      total++; if (stat_ops !== 32'h0) begin bad++; $display("FAIL reset_stat_ops got=%0d want=0", stat_ops); end
      total++; if (stat_sat !== 32'h0) begin bad++; $display("FAIL reset_stat_sat got=%0d want=0", stat_sat); end
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_small_diff();
      logic [W-1:0] va [3] = '{24'h000010, 24'hFFFFFB, 24'h000010};
      logic [W-1:0] vb [3] = '{24'h000005, 24'hFFFFF0, 24'h000005};
      logic [1:0]   vm [3] = '{2'b00, 2'b00, 2'b11};
      logic [W-1:0] ve [3] = '{24'h00001B, 24'h000006, 24'h00001B};
      logic [W-1:0] got;
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue_and_collect(va[i], vb[i], vm[i], got, lat);
         total++; if (got !== ve[i]) begin bad++; $display("FAIL small_diff[%0d] got=%h want=%h", i, got, ve[i]); end
         total++; if (lat !== 3) begin bad++; $display("FAIL small_diff_latency[%0d] got=%0d want=3", i, lat); end
      end
   endtask

   task automatic test_lut_range();
      logic [W-1:0] va [3] = '{24'h100000, 24'h0003FF, 24'h000400};
      logic [W-1:0] vb [3] = '{24'h200000, 24'h000000, 24'h000000};
      logic [W-1:0] ve [3] = '{24'h200000, 24'h0007FE, 24'h000400};
      logic [W-1:0] got;
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue_and_collect(va[i], vb[i], 2'b00, got, lat);
         total++; if (got !== ve[i]) begin bad++; $display("FAIL lut_range[%0d] got=%h want=%h", i, got, ve[i]); end
      end
   endtask

   task automatic test_neg_inf();
      logic [W-1:0] va [3] = '{24'h800000, 24'h123456, 24'h800000};
      logic [W-1:0] vb [3] = '{24'h123456, 24'h800000, 24'h800000};
      logic [W-1:0] ve [3] = '{24'h123456, 24'h123456, 24'h800000};
      logic [W-1:0] got;
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue_and_collect(va[i], vb[i], 2'b00, got, lat);
         total++; if (got !== ve[i]) begin bad++; $display("FAIL neg_inf[%0d] got=%h want=%h", i, got, ve[i]); end
      end
   endtask

   task automatic test_saturation();
      logic [W-1:0] got;
      logic [31:0]  s0, o0;
      int lat;
      write_lut(0, 5);
      s0 = stat_sat; o0 = stat_ops;
      issue_and_collect(24'h7FFFFF, 24'h7FFFFF, 2'b00, got, lat);
      total++; if (got !== 24'h7FFFFF) begin bad++; $display("FAIL saturate got=%h want=7fffff", got); end
      total++; if (stat_sat - s0 !== 32'(STATS)) begin bad++; $display("FAIL sat_count got=%0d want=%0d", stat_sat - s0, STATS); end
      total++; if (stat_ops - o0 !== 32'(STATS)) begin bad++; $display("FAIL sat_ops_count got=%0d want=%0d", stat_ops - o0, STATS); end
      // lands exactly on the maximum: not a saturation
      issue_and_collect(24'h7FFFFA, 24'h7FFFFA, 2'b00, got, lat);
      total++; if (got !== 24'h7FFFFF) begin bad++; $display("FAIL exact_max got=%h want=7fffff", got); end
      total++; if (stat_sat - s0 !== 32'(STATS)) begin bad++; $display("FAIL exact_max_count got=%0d want=%0d", stat_sat - s0, STATS); end
      write_lut(0, 0);
   endtask

   task automatic test_packed();
      logic [W-1:0] va [3] = '{24'h041041, 24'h7DF7DF, 24'h800005};
      logic [W-1:0] vb [3] = '{24'h820820, 24'hFFFFFF, 24'h7FF800};
      logic [1:0]   vm [3] = '{2'b01, 2'b01, 2'b10};
      logic [W-1:0] ve [3] = '{24'h041041, 24'h7DF7DF, 24'h7FF005};
      logic [W-1:0] got;
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue_and_collect(va[i], vb[i], vm[i], got, lat);
         total++; if (got !== ve[i]) begin bad++; $display("FAIL packed[%0d] got=%h want=%h", i, got, ve[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] res [5];
      int           cyc [5];
      logic [W-1:0] got;
      logic         hs_out, acc;
      logic [31:0]  o0;
      int idx, n, t;
      o0 = stat_ops; idx = 0; n = 0; t = 0;
      bus.out_ready = 1'b0;
      bus.in_a = 24'h000100; bus.in_b = 24'h0000FF; bus.in_mode = 2'b00; bus.in_valid = 1'b1;
      while (t < 36 && n < 5) begin
         if (t == 6) begin
            total++; if (idx !== 3) begin bad++; $display("FAIL bp_accepted got=%0d want=3", idx); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
            bus.out_ready = 1'b1;
         end
         #2;
         hs_out = bus.out_valid && bus.out_ready;
         got    = bus.out_result;
         acc    = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (hs_out) begin res[n] = got; cyc[n] = t; n++; end
         if (acc) begin
            idx++;
            if (idx < 5) begin
               bus.in_a = 24'(32'h100 * (idx + 1));
               bus.in_b = 24'(32'h100 * (idx + 1) - (idx + 1));
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         t++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      total++; if (n !== 5) begin bad++; $display("FAIL bp_outputs got=%0d want=5", n); end
      for (int k = 0; k < n; k++) begin
         total++; if (res[k] !== 24'(32'h101 * (k + 1))) begin bad++; $display("FAIL bp_result[%0d] got=%h want=%h", k, res[k], 24'(32'h101 * (k + 1))); end
         total++; if (cyc[k] !== cyc[0] + k) begin bad++; $display("FAIL bp_cycle[%0d] got=%0d want=%0d", k, cyc[k], cyc[0] + k); end
      end
      total++; if (stat_ops - o0 !== 32'(5 * STATS)) begin bad++; $display("FAIL bp_stat_ops got=%0d want=%0d", stat_ops - o0, 5 * STATS); end
   endtask

   task automatic test_lut_visibility();
      logic [W-1:0] got;
      int lat;
      bus.in_a = 24'h000020; bus.in_b = 24'h00001D; bus.in_mode = 2'b00; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lut_addr = 10'd3; lut_wdata = 10'd100; lut_we = 1'b1;
      @(posedge clk); #1;
      lut_we = 1'b0;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL vis_old_valid got=%b want=1", bus.out_valid); end
      total++; if (bus.out_result !== 24'h000023) begin bad++; $display("FAIL vis_old got=%h want=000023", bus.out_result); end
      @(posedge clk); #1;
      issue_and_collect(24'h000020, 24'h00001D, 2'b00, got, lat);
      total++; if (got !== 24'h000084) begin bad++; $display("FAIL vis_new got=%h want=000084", got); end
   endtask

   task automatic test_reset_mid();
      int t;
      bus.out_ready = 1'b0;
      bus.in_a = 24'h000010; bus.in_b = 24'h000005; bus.in_mode = 2'b00; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      t = 0;
      while (!bus.out_valid && t < 10) begin @(posedge clk); #1; t++; end
      total++; if (bus.out_result !== 24'h00001B) begin bad++; $display("FAIL mid_pre_result got=%h want=00001b", bus.out_result); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.out_result !== 24'h0) begin bad++; $display("FAIL mid_out_result got=%h want=000000", bus.out_result); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", bus.in_ready); end
      total++; if (stat_ops !== 32'h0) begin bad++; $display("FAIL mid_stat_ops got=%0d want=0", stat_ops); end
      @(posedge clk); #2;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_post_valid got=%b want=0", bus.out_valid); end
   endtask

   initial begin
      test_reset();
      load_lut_identity();
      test_small_diff();
      test_lut_range();
      test_neg_inf();
      test_saturation();
      test_packed();
      test_back_to_back();
      test_lut_visibility();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
